branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Resolves conditional branches one stage downstream of the ALU and keeps a 2-bit saturating branch history table (BHT) that fetch consults for predictions. Each cycle it takes the ALU's `Branch_Enable` result for the branch in EX, compares it with the prediction carried down the pipeline, trains the BHT and, on a mismatch, drives a registered redirect PC and a multi-cycle flush to the front end. It also keeps branch and mispredict counters for performance measurement.

## Interface
Parameters:
- `BHT_IDX_W`, 4, BHT index width; the table has 2^BHT_IDX_W entries indexed by PC[BHT_IDX_W+1:2].
- `FLUSH_CYCLES`, 2, number of cycles `flush` stays high after a mispredict (range 1..7).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `pred_valid`  in  1  fetch has a decoded conditional branch at `pred_pc`.
- `pred_pc`  in  32  PC of the fetched branch.
- `pred_offset`  in  32  sign-extended B-type immediate.
- `pred_taken`  out  1  combinational: `pred_valid & BHT[idx(pred_pc)][1]`.
- `pred_target`  out  32  combinational: `pred_pc + pred_offset` (mod 2^32).
- `ex_valid`  in  1  EX-stage instruction is valid.
- `ex_is_branch`  in  1  EX-stage instruction is a conditional branch.
- `ex_pc`  in  32  PC of the EX-stage branch.
- `ex_target`  in  32  taken-target of the EX-stage branch.
- `ex_pred_taken`  in  1  prediction made for this branch at fetch.
- `branch_enable`  in  1  ALU branch outcome (1 = taken).
- `stall`  in  1  EX is held this cycle; its inputs are repeated next cycle.
- `mispredict`  out  1  registered single-cycle pulse.
- `redirect_pc`  out  32  registered; valid while `mispredict` is high, holds value otherwise.
- `flush`  out  1  registered; squashes IF/ID/EX.
- `branch_count`  out  32  resolved branches since reset.
- `mispredict_count`  out  32  mispredicts since reset.

## Operation
- Resolve event R = `ex_valid & ex_is_branch & ~stall & (state == NORMAL)`.
- On R: update BHT[idx(ex_pc)]. If `branch_enable`, increment, saturating at 2'b11; otherwise decrement, saturating at 2'b00. Increment `branch_count`.
- Mispredict M = R & (`branch_enable != ex_pred_taken`). On M: `redirect_pc <= branch_enable ? ex_target : ex_pc + 4`, `mispredict <= 1`, `mispredict_count` increments, and the FSM enters FLUSH with `flush_cnt <= FLUSH_CYCLES-1`.
- FSM states:
  - NORMAL: `flush = 0`.
  - FLUSH: `flush = 1`. `flush_cnt` decrements every cycle, regardless of `stall`. When `flush_cnt == 0`, the FSM returns to NORMAL.
- While in FLUSH, EX inputs are ignored: no BHT training and no counting. A second M therefore cannot be raised during a flush.
- Counters wrap modulo 2^32. All PC arithmetic is modulo 2^32.
- Reset (async, `rst_n` low): every BHT entry = 2'b01 (weakly not-taken); `mispredict = 0`, `flush = 0`, `redirect_pc = 0`, both counters = 0, state = NORMAL. Asserting reset in the middle of a flush aborts it immediately.

## Timing
- Prediction path (`pred_taken`, `pred_target`) is combinational, with zero latency from `pred_pc`.
- Simultaneous prediction read and training of the same index: the read returns the pre-update value. There is no bypass.
- Resolution: a branch resolving in cycle N produces `mispredict`/`redirect_pc` in cycle N+1. `flush` is high in cycles N+1 .. N+FLUSH_CYCLES, and NORMAL resumes in cycle N+FLUSH_CYCLES+1.
- A branch held by `stall` for k cycles trains the BHT and counts exactly once, on its non-stalled cycle.
- `ex_valid` with `ex_is_branch = 0` has no effect.

## Structure
- Add to the shared defines include:
  - BHT counter encodings: SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11.
  - FSM state encodings: NORMAL, FLUSH.
  - The BHT reset value (WNT).
- One sub-module, `bht_table`. It contains the 2^BHT_IDX_W × 2-bit array with async-low reset, one combinational read port, and one saturating-update write port (`we`, `widx`, `taken`).
- The FSM, redirect register and counters live in `branch_resolve_unit`.

## Test plan
- After reset, with `pred_pc = 0x100`, `pred_offset = 0x20`, `pred_valid = 1`: `pred_taken = 0`, `pred_target = 0x120`. All outputs are 0.
- Resolve `ex_pc = 0x100` with `branch_enable = 1` and `ex_pred_taken = 0`: in the next cycle `mispredict = 1` and `redirect_pc = ex_target`. `flush` is high for exactly 2 cycles, and `mispredict_count = 1`.
- Train index 0 taken ×3, then not-taken ×1. The counter sequence is 01→10→11→11→10, and `pred_taken` for 0x100 stays 1 after the not-taken.
- Not-taken mispredict at `ex_pc = 0xFFFFFFFC`: `redirect_pc = 0x00000000` (wrap).
- Hold a branch under `stall` for 3 cycles, then release: `branch_count` increments once and the BHT updates once. A branch presented during `flush` is ignored.
- Drop `rst_n` mid-flush: `flush`, `mispredict` and the counters clear asynchronously, and all BHT entries return to 01.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// branch_resolve_unit_pkg: shared encodings and the BHT saturating-counter update.
package branch_resolve_unit_pkg;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} bht_ctr_e;
  typedef enum logic {NORMAL = 1'b0, FLUSH = 1'b1} state_e;
  localparam bht_ctr_e BHT_RST = WNT;
  function automatic logic [1:0] sat_update(input logic [1:0] c, input logic taken);
    return taken ? ((c == ST) ? c : c + 2'd1) : ((c == SNT) ? c : c - 2'd1);
  endfunction
endpackage

// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: fetch prediction and EX resolution bus between the pipeline and the resolve unit.
interface branch_resolve_unit_if;
  import branch_resolve_unit_pkg::*;
  logic            pred_valid;
  logic [XLEN-1:0] pred_pc;
  logic [XLEN-1:0] pred_offset;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            ex_valid;
  logic            ex_is_branch;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_target;
  logic            ex_pred_taken;
  logic            branch_enable;
  logic            stall;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic [XLEN-1:0] branch_count;
  logic [XLEN-1:0] mispredict_count;
  modport master (
    output pred_valid, pred_pc, pred_offset, ex_valid, ex_is_branch, ex_pc, ex_target,
           ex_pred_taken, branch_enable, stall,
    input  pred_taken, pred_target, mispredict, redirect_pc, flush, branch_count, mispredict_count
  );
  modport slave (
    input  pred_valid, pred_pc, pred_offset, ex_valid, ex_is_branch, ex_pc, ex_target,
           ex_pred_taken, branch_enable, stall,
    output pred_taken, pred_target, mispredict, redirect_pc, flush, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_resolve_unit_bht_table.sv
// bht_table: 2-bit saturating branch history table, one async read port and one training port.
module bht_table
  import branch_resolve_unit_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] ridx,
  output logic [1:0]       rdata,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic             taken
);
  logic [1:0] mem_q [2**IDX_W];
  // Read sees the pre-update value when ridx == widx; no bypass is intended.
  assign rdata = mem_q[ridx];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**IDX_W; i++) mem_q[i] <= BHT_RST;
    end else if (we) begin
      mem_q[widx] <= sat_update(mem_q[widx], taken);
    end
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves EX branches against predictions, trains the BHT and drives redirect/flush.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int BHT_IDX_W    = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  branch_resolve_unit_if.slave bus
);
  state_e          state_q;
  logic [2:0]      flush_cnt_q;
  logic            mispredict_q;
  logic            flush_q;
  logic [XLEN-1:0] redirect_q;
  logic [XLEN-1:0] branch_cnt_q;
  logic [XLEN-1:0] mispredict_cnt_q;
  logic [1:0]      rd_ctr;
  logic            resolve;
  logic            mispred;
  // EX is ignored during a flush, so a second mispredict cannot start mid-flush.
  assign resolve = bus.ex_valid & bus.ex_is_branch & ~bus.stall & (state_q == NORMAL);
  assign mispred = resolve & (bus.branch_enable != bus.ex_pred_taken);
  bht_table #(.IDX_W(BHT_IDX_W)) u_bht (
    .clk   (clk),
    .rst_n (rst_n),
    .ridx  (bus.pred_pc[BHT_IDX_W+1:2]),
    .rdata (rd_ctr),
    .we    (resolve),
    .widx  (bus.ex_pc[BHT_IDX_W+1:2]),
    .taken (bus.branch_enable)
  );
  assign bus.pred_taken       = bus.pred_valid & rd_ctr[1];
  assign bus.pred_target      = bus.pred_pc + bus.pred_offset;
  assign bus.mispredict       = mispredict_q;
  assign bus.redirect_pc      = redirect_q;
  assign bus.flush            = flush_q;
  assign bus.branch_count     = branch_cnt_q;
  assign bus.mispredict_count = mispredict_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= NORMAL;
      flush_cnt_q      <= '0;
      mispredict_q     <= 1'b0;
      flush_q          <= 1'b0;
      redirect_q       <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      mispredict_q     <= mispred;
      redirect_q       <= mispred ? (bus.branch_enable ? bus.ex_target : bus.ex_pc + 32'd4) : redirect_q;
      branch_cnt_q     <= branch_cnt_q + {31'd0, resolve};
      mispredict_cnt_q <= mispredict_cnt_q + {31'd0, mispred};
      case (state_q)
        NORMAL: if (mispred) begin
          state_q     <= FLUSH;
          flush_q     <= 1'b1;
          flush_cnt_q <= 3'(FLUSH_CYCLES - 1);
        end
        FLUSH: if (flush_cnt_q == 3'd0) begin
          state_q <= NORMAL;
          flush_q <= 1'b0;
        end else begin
          flush_cnt_q <= flush_cnt_q - 3'd1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_branch_resolve_unit;
  localparam int FC = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int bht[16];
  int unsigned m_bc, m_mc;
  int flush_left;
  bit m_misp;
  logic [31:0] m_redir;

  branch_resolve_unit_if bus();
  branch_resolve_unit #(.BHT_IDX_W(4), .FLUSH_CYCLES(FC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic model_reset();
    foreach (bht[i]) bht[i] = 1;
    m_bc = 0; m_mc = 0; flush_left = 0; m_misp = 0; m_redir = 0;
  endtask

  // Model of one rising edge, using the inputs currently on the bus.
  task automatic model_edge();
    bit r;
    int i;
    r = bus.ex_valid && bus.ex_is_branch && !bus.stall && flush_left == 0;
    i = int'(bus.ex_pc[5:2]);
    if (flush_left > 0) flush_left--;
    m_misp = r && (bus.branch_enable != bus.ex_pred_taken);
    if (r) begin
      bht[i] = bus.branch_enable ? (bht[i] == 3 ? 3 : bht[i] + 1) : (bht[i] == 0 ? 0 : bht[i] - 1);
      m_bc++;
    end
    if (m_misp) begin
      m_mc++;
      m_redir = bus.branch_enable ? bus.ex_target : bus.ex_pc + 32'd4;
      flush_left = FC;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive_ex(bit v, bit b, logic [31:0] pc, logic [31:0] tgt, bit pt, bit be, bit st);
    bus.ex_valid = v; bus.ex_is_branch = b; bus.ex_pc = pc; bus.ex_target = tgt;
    bus.ex_pred_taken = pt; bus.branch_enable = be; bus.stall = st;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_ex(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.pred_valid = 1; bus.pred_pc = 32'h100; bus.pred_offset = 32'h20;
    drive_ex(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken: got %b expected 0", bus.pred_taken); end
    checks++; if (bus.pred_target !== 32'h120) begin errors++; $display("FAIL reset_pred_target: got %h expected 00000120", bus.pred_target); end
    checks++; if ({bus.mispredict, bus.flush} !== 2'b00) begin errors++; $display("FAIL reset_misp_flush: got %b expected 00", {bus.mispredict, bus.flush}); end
    checks++; if (bus.redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect: got %h expected 0", bus.redirect_pc); end
    checks++; if ({bus.branch_count, bus.mispredict_count} !== 64'h0) begin errors++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", bus.branch_count, bus.mispredict_count); end
  endtask

  task automatic test_mispredict();
    int hi = 0;
    @(negedge clk);
    drive_ex(1, 1, 32'h100, 32'h2000, 0, 1, 0);
    tick();
    checks++; if (bus.mispredict !== 1'b1) begin errors++; $display("FAIL misp_pulse: got %b expected 1", bus.mispredict); end
    checks++; if (bus.redirect_pc !== 32'h2000) begin errors++; $display("FAIL misp_redirect: got %h expected 00002000", bus.redirect_pc); end
    checks++; if (bus.mispredict_count !== 32'd1) begin errors++; $display("FAIL misp_count: got %0d expected 1", bus.mispredict_count); end
    @(negedge clk);
    drive_ex(0, 0, 0, 0, 0, 0, 0);
    hi = bus.flush;
    for (int c = 0; c < 4; c++) begin
      tick();
      hi += bus.flush;
    end
    checks++; if (hi !== 2) begin errors++; $display("FAIL flush_len: got %0d expected 2", hi); end
    checks++; if (bus.mispredict !== 1'b0) begin errors++; $display("FAIL misp_single: got %b expected 0", bus.mispredict); end
  endtask

  task automatic test_training();
    int exp_seq[4] = '{2, 3, 3, 2};
    do_reset();
    bus.pred_valid = 1; bus.pred_pc = 32'h100;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive_ex(1, 1, 32'h100, 32'h180, k < 3, k < 3, 0);
      tick();
      checks++; if (dut.u_bht.mem_q[0] !== 2'(exp_seq[k])) begin errors++; $display("FAIL train_ctr%0d: got %0d expected %0d", k, dut.u_bht.mem_q[0], exp_seq[k]); end
      checks++; if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL train_pred%0d: got %b expected 1", k, bus.pred_taken); end
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    drive_ex(1, 1, 32'hFFFF_FFFC, 32'h40, 1, 0, 0);
    tick();
    checks++; if ({bus.mispredict, bus.redirect_pc} !== {1'b1, 32'h0}) begin errors++; $display("FAIL wrap_redirect: got %b/%h expected 1/00000000", bus.mispredict, bus.redirect_pc); end
    @(negedge clk);
    drive_ex(0, 0, 0, 0, 0, 0, 0);
    repeat (FC + 1) tick();
  endtask

  task automatic test_stall();
    logic [31:0] bc0 = bus.branch_count;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive_ex(1, 1, 32'h108, 32'h300, 1, 1, 1);
      tick();
      checks++; if (bus.branch_count !== bc0 || dut.u_bht.mem_q[2] !== 2'b01) begin errors++; $display("FAIL stall_hold%0d: got %0d/%0d expected %0d/1", k, bus.branch_count, dut.u_bht.mem_q[2], bc0); end
    end
    @(negedge clk);
    bus.stall = 0;
    tick();
    checks++; if (bus.branch_count !== bc0 + 1 || dut.u_bht.mem_q[2] !== 2'b10) begin errors++; $display("FAIL stall_release: got %0d/%0d expected %0d/2", bus.branch_count, dut.u_bht.mem_q[2], bc0 + 1); end
    @(negedge clk);
    drive_ex(1, 1, 32'h10C, 32'h400, 0, 1, 0);
    tick();
    @(negedge clk);
    drive_ex(1, 1, 32'h110, 32'h500, 1, 0, 0);
    tick();
    checks++; if (bus.mispredict !== 1'b0 || bus.branch_count !== bc0 + 2 || dut.u_bht.mem_q[4] !== 2'b01) begin errors++; $display("FAIL flush_ignore: got %b/%0d/%0d expected 0/%0d/1", bus.mispredict, bus.branch_count, dut.u_bht.mem_q[4], bc0 + 2); end
    @(negedge clk);
    drive_ex(0, 0, 0, 0, 0, 0, 0);
    repeat (FC + 1) tick();
  endtask

  task automatic test_reset_mid_flush();
    int bad = 0;
    @(negedge clk);
    drive_ex(1, 1, 32'h104, 32'h600, 0, 1, 0);
    tick();
    @(negedge clk);
    drive_ex(0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus.flush, bus.mispredict} !== 2'b00) begin errors++; $display("FAIL async_flush: got %b expected 00", {bus.flush, bus.mispredict}); end
    checks++; if ({bus.branch_count, bus.mispredict_count} !== 64'h0) begin errors++; $display("FAIL async_counts: got %0d/%0d expected 0/0", bus.branch_count, bus.mispredict_count); end
    for (int i = 0; i < 16; i++) bad += (dut.u_bht.mem_q[i] !== 2'b01);
    checks++; if (bad !== 0) begin errors++; $display("FAIL async_bht: got %0d entries wrong expected 0", bad); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    bit ept;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      bus.pred_valid = $urandom_range(3) != 0;
      bus.pred_pc = ($urandom_range(7) == 0) ? $urandom : {26'd0, 4'($urandom_range(15)), 2'b00};
      bus.pred_offset = $urandom;
      drive_ex($urandom_range(7) != 0, $urandom_range(3) != 0,
               ($urandom_range(15) == 0) ? 32'hFFFF_FFFC : {$urandom_range(255), 4'($urandom_range(15)), 2'b00} & 32'hFFFF_FFFC,
               $urandom, $urandom_range(1), $urandom_range(1), $urandom_range(3) == 0);
      #1;
      ept = bus.pred_valid && bht[bus.pred_pc[5:2]] >= 2;
      checks++; if (bus.pred_taken !== ept || bus.pred_target !== bus.pred_pc + bus.pred_offset) begin errors++; $display("FAIL rnd_pred%0d: got %b/%h expected %b/%h", n, bus.pred_taken, bus.pred_target, ept, bus.pred_pc + bus.pred_offset); end
      tick();
      checks++; if (bus.mispredict !== m_misp || bus.redirect_pc !== m_redir || bus.flush !== (flush_left > 0)) begin errors++; $display("FAIL rnd_resolve%0d: got %b/%h/%b expected %b/%h/%b", n, bus.mispredict, bus.redirect_pc, bus.flush, m_misp, m_redir, flush_left > 0); end
      checks++; if (bus.branch_count !== m_bc || bus.mispredict_count !== m_mc) begin errors++; $display("FAIL rnd_counts%0d: got %0d/%0d expected %0d/%0d", n, bus.branch_count, bus.mispredict_count, m_bc, m_mc); end
    end
  endtask

  initial begin
    test_reset();
    test_mispredict();
    test_training();
    test_wrap();
    test_stall();
    test_reset_mid_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
